// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-pass shift/rotate controller around a 4-bit barrel_shifter.
// A request is split into passes of at most 3 bits. The intermediate value is held
// in acc between passes, so the datapath never needs more than a 3-bit shift.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both high.
// The producer must hold its fields stable until that edge. The consumer may stall
// for any length of time. in_ready is high only in IDLE and out_valid only in DONE,
// so a result transfer and a new accept can never happen on the same edge.

// barrel_shifter: single-pass 4-bit shift or rotate by 0..3 positions.
module barrel_shifter (
    input  logic [3:0] din,
    input  logic       select,
    input  logic       direction,
    input  logic [1:0] shift_value,
    output logic [3:0] dout
);
    logic [7:0] rot_l;
    logic [7:0] rot_r;

    // Pick the zero-fill shift or rotate result for the requested direction.
    always_comb begin
        rot_l = {din, din} << shift_value;
        rot_r = {din, din} >> shift_value;
        case ({select, direction})
            2'b00:   dout = din >> shift_value;
            2'b01:   dout = din << shift_value;
            2'b10:   dout = rot_r[3:0];
            default: dout = rot_l[7:4];
        endcase
    end
endmodule

module shift_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       select,
    input  logic       direction,
    input  logic [3:0] amount,
    input  logic [3:0] din,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] dout,
    output logic       busy,
    output logic [1:0] dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] acc;
    logic [3:0] remaining;
    logic       op_sel;
    logic       op_dir;
    logic [1:0] step;
    logic [3:0] rem_next;
    logic [3:0] pass_out;

    // Largest pass the datapath allows, then whatever residue is left.
    always_comb begin
        step     = (remaining >= 4'd3) ? 2'd3 : remaining[1:0];
        rem_next = remaining - {2'b00, step};
    end

    barrel_shifter u_shifter (
        .din         (acc),
        .select      (op_sel),
        .direction   (op_dir),
        .shift_value (step),
        .dout        (pass_out)
    );

    // Sequencer FSM: accept a request, run the passes, hold the result until it is consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= 4'd0;
            remaining <= 4'd0;
            op_sel    <= 1'b0;
            op_dir    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc       <= din;
                        remaining <= amount;
                        op_sel    <= select;
                        op_dir    <= direction;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        if (amount != 4'd0) begin
                            state <= SHIFT;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    acc       <= pass_out;
                    remaining <= rem_next;
                    if (rem_next == 4'd0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign dout      = acc;
    assign dbg_state = state;
endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed table, random requests against a reference
// model, backpressure and mid-operation reset.
module tb_shift_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       select;
    logic       direction;
    logic [3:0] amount;
    logic [3:0] din;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] dout;
    logic       busy;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        logic       sel;
        logic       dir;
        logic [3:0] amt;
        logic [3:0] din;
        logic [3:0] dout;
        int         lat;
        int         hold;
    } vec_t;

    vec_t vecs[12];

    shift_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .select    (select),
        .direction (direction),
        .amount    (amount),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: shifts of 4 or more clear the word; rotates move bit by bit, amount mod 4 times.
    function automatic logic [3:0] ref_op(input logic sel, input logic dir,
                                          input logic [3:0] amt, input logic [3:0] d);
        logic [3:0] v;
        int n;
        v = d;
        if (!sel) begin
            if (amt >= 4) v = 4'd0;
            else v = dir ? (d << amt) : (d >> amt);
        end else begin
            n = int'(amt) % 4;
            for (int i = 0; i < n; i++)
                v = dir ? {v[2:0], v[3]} : {v[0], v[3:1]};
        end
        return v;
    endfunction

    function automatic int ref_lat(input logic [3:0] amt);
        return (int'(amt) + 2) / 3;
    endfunction

    task automatic scramble_inputs();
        select    = 1'($urandom_range(0, 1));
        direction = 1'($urandom_range(0, 1));
        amount    = 4'($urandom_range(0, 15));
        din       = 4'($urandom_range(0, 15));
    endtask

    // Driver: one full request/response; expected value is taken from exp_q.
    task automatic run_req(input logic sel, input logic dir, input logic [3:0] amt,
                           input logic [3:0] d, input int lat, input int hold, input bit pulse);
        int guard;
        int cnt;
        bit timeout;
        logic [3:0] exp_v;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_idle", in_ready, 1);
        select    = sel;
        direction = dir;
        amount    = amt;
        din       = d;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble_inputs();
        @(negedge clk);
        check("busy_after_accept", busy, 1);
        check("in_ready_low_busy", in_ready, 0);
        cnt = 0;
        timeout = 1'b0;
        while (!out_valid) begin
            if (cnt >= 40) begin
                timeout = 1'b1;
                break;
            end
            if (pulse) begin
                in_valid = 1'($urandom_range(0, 1));
                scramble_inputs();
            end
            @(negedge clk);
            cnt++;
        end
        in_valid = 1'b0;
        exp_v = exp_q.pop_front();
        check("out_valid_timeout", int'(timeout), 0);
        if (timeout) return;
        check("latency", cnt, lat);
        check("dout", dout, exp_v);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_dout", dout, exp_v);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("out_valid_cleared", out_valid, 0);
        check("busy_cleared", busy, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    initial begin
        bit seen;
        logic s, dr;
        logic [3:0] a, d;

        // sel, dir(1=left), amt, din, expected dout, passes, backpressure cycles
        vecs[0]  = '{1'b1, 1'b1, 4'd5,  4'b1011, 4'b0111, 2, 0};
        vecs[1]  = '{1'b0, 1'b0, 4'd7,  4'b1011, 4'b0000, 3, 1};
        vecs[2]  = '{1'b1, 1'b0, 4'd15, 4'b1001, 4'b0011, 5, 0};
        vecs[3]  = '{1'b0, 1'b0, 4'd0,  4'b0110, 4'b0110, 0, 4};
        vecs[4]  = '{1'b0, 1'b1, 4'd1,  4'b1011, 4'b0110, 1, 0};
        vecs[5]  = '{1'b0, 1'b1, 4'd2,  4'b0011, 4'b1100, 1, 2};
        vecs[6]  = '{1'b0, 1'b0, 4'd3,  4'b1000, 4'b0001, 1, 0};
        vecs[7]  = '{1'b1, 1'b1, 4'd4,  4'b1010, 4'b1010, 2, 0};
        vecs[8]  = '{1'b1, 1'b0, 4'd2,  4'b0001, 4'b0100, 1, 1};
        vecs[9]  = '{1'b0, 1'b1, 4'd4,  4'b0001, 4'b0000, 2, 0};
        vecs[10] = '{1'b1, 1'b1, 4'd6,  4'b1000, 4'b0010, 2, 0};
        vecs[11] = '{1'b0, 1'b0, 4'd2,  4'b1100, 4'b0011, 1, 3};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        select    = 1'b0;
        direction = 1'b0;
        amount    = 4'd0;
        din       = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_dout", dout, 0);
        check("rst_state", dbg_state, 0);

        // Directed table; in_valid pulses during SHIFT for the 15-bit rotate.
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(vecs[i].dout);
            run_req(vecs[i].sel, vecs[i].dir, vecs[i].amt, vecs[i].din,
                    vecs[i].lat, vecs[i].hold, i == 2);
        end

        // Random requests against the reference model.
        for (int i = 0; i < 40; i++) begin
            s  = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            a  = 4'($urandom_range(0, 15));
            d  = 4'($urandom_range(0, 15));
            exp_q.push_back(ref_op(s, dr, a, d));
            run_req(s, dr, a, d, ref_lat(a), $urandom_range(0, 3), 1'b1);
        end

        // Shift left 1, then abort a shift left 12 with reset during its second SHIFT cycle.
        exp_q.push_back(4'b0110);
        run_req(1'b0, 1'b1, 4'd1, 4'b1011, 1, 0, 1'b0);
        @(negedge clk);
        select    = 1'b0;
        direction = 1'b1;
        amount    = 4'd12;
        din       = 4'b1111;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        check("pre_abort_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_dout", dout, 0);
        check("abort_state", dbg_state, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("no_output_after_abort", int'(seen), 0);

        // Recovery after the abort.
        exp_q.push_back(4'b0000);
        run_req(1'b0, 1'b1, 4'd12, 4'b1111, 4, 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
